// File: rtl/vdu_pkg.sv
// Shared types and defaults for the VDU video RAM arbiter.
package vdu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VID_ACC = 2'd1,
    CPU_ACC = 2'd2,
    CPU_ACK = 2'd3
  } arb_state_e;

  localparam int DEF_RAM_WAIT   = 2;
  localparam int DEF_CPU_STARVE = 4;
  localparam int ADDR_W         = 14;
  localparam int DATA_W         = 8;

endpackage

// File: rtl/vdu_sync2.sv
// Two-flop synchronizer; resets to 1 so an idle (high) strobe reads inactive.
module vdu_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vdu_vram_arbiter.sv
// Shares a single VRAM port between scan-out fetches and STEbus CPU cycles,
// favouring video but bounding CPU starvation to CPU_STARVE video grants.
module vdu_vram_arbiter
  import vdu_pkg::*;
#(
  parameter int RAM_WAIT   = DEF_RAM_WAIT,
  parameter int CPU_STARVE = DEF_CPU_STARVE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_din,
  output logic [DATA_W-1:0] bus_dout,
  output logic              datack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int SW = $clog2(CPU_STARVE + 1);

  arb_state_e        state, state_nxt;
  logic              cs_s, cpu_done, cpu_pend, cpu_wr;
  logic              vid_pend, vid_any, vid_grant, cpu_grant, acc_last;
  logic [ADDR_W-1:0] vid_pend_addr, vid_grant_addr;
  logic [SW-1:0]     vid_streak;
  logic [2:0]        wait_cnt;

  vdu_sync2 u_cs_sync (.clk(clk), .reset_n(reset_n), .d(cs), .q(cs_s));

  // A request arriving while IDLE is granted directly, so it counts as pending now.
  assign cpu_pend       = !cs_s && !cpu_done;
  assign vid_any        = vid_pend || vid_req;
  assign vid_grant_addr = vid_pend ? vid_pend_addr : vid_addr;
  assign acc_last       = (wait_cnt == 3'(RAM_WAIT - 1));

  always_comb begin
    state_nxt = state;
    vid_grant = 1'b0;
    cpu_grant = 1'b0;
    case (state)
      IDLE: begin
        if (vid_any && (!cpu_pend || vid_streak < SW'(CPU_STARVE))) begin
          state_nxt = VID_ACC;
          vid_grant = 1'b1;
        end else if (cpu_pend) begin
          state_nxt = CPU_ACC;
          cpu_grant = 1'b1;
        end
      end
      VID_ACC: if (acc_last) state_nxt = IDLE;
      CPU_ACC: if (acc_last) state_nxt = cs_s ? IDLE : CPU_ACK;
      CPU_ACK: if (cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_oe_n = !(state == VID_ACC || (state == CPU_ACC && !cpu_wr));
  assign ram_we_n = !(state == CPU_ACC && cpu_wr);
  assign datack   = (state != CPU_ACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      cpu_done      <= 1'b0;
      cpu_wr        <= 1'b0;
      vid_pend      <= 1'b0;
      vid_pend_addr <= '0;
      vid_overrun   <= 1'b0;
      vid_streak    <= '0;
      vid_valid     <= 1'b0;
      vid_data      <= '0;
      bus_dout      <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= ((state == VID_ACC || state == CPU_ACC) && !acc_last) ? wait_cnt + 3'd1 : 3'd0;
      vid_valid <= (state == VID_ACC) && acc_last;
      if (state == VID_ACC && acc_last) vid_data <= ram_rdata;
      if (state == CPU_ACC && acc_last && !cpu_wr) bus_dout <= ram_rdata;

      if (cs_s)           cpu_done <= 1'b0;
      else if (cpu_grant) cpu_done <= 1'b1;

      if (cpu_grant || !cpu_pend)                           vid_streak <= '0;
      else if (vid_grant && vid_streak != SW'(CPU_STARVE)) vid_streak <= vid_streak + SW'(1);

      if (vid_grant) ram_addr <= vid_grant_addr;
      if (cpu_grant) begin
        ram_addr  <= bus_addr;
        ram_wdata <= bus_din;
        cpu_wr    <= wr;
      end

      // Granting the queued entry frees the slot for a same-cycle request.
      if (vid_grant) begin
        vid_pend      <= vid_pend && vid_req;
        vid_pend_addr <= vid_addr;
      end else if (vid_req) begin
        if (vid_pend) vid_overrun <= 1'b1;
        vid_pend      <= 1'b1;
        vid_pend_addr <= vid_addr;
      end
    end
  end

endmodule

// File: tb/tb_vdu_vram_arbiter.sv
// Directed bench: table of single accesses plus hand-built contention/overrun/abort/reset sequences.
module tb_vdu_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b1;
  logic        wr = 1'b0;
  logic [13:0] bus_addr = '0;
  logic [7:0]  bus_din = '0;
  logic [7:0]  bus_dout;
  logic        datack;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid, vid_overrun;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_oe_n, ram_we_n;
  logic        model_en = 1'b0;
  logic [7:0]  fix_rd = '0;

  int checks = 0;
  int failures = 0;

  assign ram_rdata = model_en ? (ram_addr[7:0] ^ 8'h5C) : fix_rd;

  always #5 clk = ~clk;

  vdu_vram_arbiter #(.RAM_WAIT(2), .CPU_STARVE(4)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .wr(wr), .bus_addr(bus_addr),
    .bus_din(bus_din), .bus_dout(bus_dout), .datack(datack), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .vid_overrun(vid_overrun), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  typedef struct {
    int          kind;      // 0 video fetch, 1 cpu read, 2 cpu write
    logic [13:0] addr;
    logic [7:0]  din;
    logic [7:0]  rdata;
    logic [7:0]  exp_data;  // vid_data (video) or bus_dout (cpu) afterwards
    logic [7:0]  exp_other; // the other requester's held data
    int          exp_first, exp_oe, exp_we, exp_evt, exp_ack, exp_val;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cs = 1'b1; vid_req = 1'b0; wr = 1'b0; model_en = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int oe_c = 0, we_c = 0, first = -1, evt = -1, ack_c = 0, val_c = 0;
    bit addr_ok = 1, wd_ok = 1, rel = 0;
    string t;
    t = $sformatf("vec%0d", idx);
    fix_rd = v.rdata;
    if (v.kind == 0) begin
      vid_req = 1'b1; vid_addr = v.addr;
    end else begin
      cs = 1'b0; wr = (v.kind == 2); bus_addr = v.addr; bus_din = v.din;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!ram_oe_n || !ram_we_n) begin
        if (first < 0) first = c;
        if (ram_addr !== v.addr) addr_ok = 0;
      end
      if (!ram_oe_n) oe_c++;
      if (!ram_we_n) begin
        we_c++;
        if (ram_wdata !== v.din) wd_ok = 0;
      end
      if (vid_valid === 1'b1) begin val_c++; if (evt < 0) evt = c; end
      if (datack === 1'b0) begin ack_c++; if (evt < 0) evt = c; rel = 1; end
      @(posedge clk); #1;
      vid_req = 1'b0;
      if (rel) cs = 1'b1;
    end
    chk({t, "_first_strobe"}, first, v.exp_first);
    chk({t, "_oe_cycles"}, oe_c, v.exp_oe);
    chk({t, "_we_cycles"}, we_c, v.exp_we);
    chk({t, "_event_cycle"}, evt, v.exp_evt);
    chk({t, "_datack_cycles"}, ack_c, v.exp_ack);
    chk({t, "_valid_count"}, val_c, v.exp_val);
    chk({t, "_ram_addr"}, 32'(addr_ok), 32'd1);
    if (v.kind == 2) chk({t, "_ram_wdata"}, 32'(wd_ok), 32'd1);
    if (v.kind == 0) begin
      chk({t, "_vid_data"}, 32'(vid_data), 32'(v.exp_data));
      chk({t, "_bus_dout_hold"}, 32'(bus_dout), 32'(v.exp_other));
    end else begin
      chk({t, "_bus_dout"}, 32'(bus_dout), 32'(v.exp_data));
      chk({t, "_vid_data_hold"}, 32'(vid_data), 32'(v.exp_other));
    end
  endtask

  initial begin
    //           kind addr      din    rdata  exp    other  first oe we evt ack val
    vecs[0] = '{0, 14'h0123, 8'h00, 8'h5A, 8'h5A, 8'h00, 1, 2, 0, 3, 0, 1};
    vecs[1] = '{0, 14'h3FFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 1, 2, 0, 3, 0, 1};
    vecs[2] = '{1, 14'h0200, 8'h00, 8'hC3, 8'hC3, 8'hFF, 3, 2, 0, 5, 4, 0};
    vecs[3] = '{2, 14'h1555, 8'h7E, 8'h99, 8'hC3, 8'hFF, 3, 0, 2, 5, 4, 0};
    vecs[4] = '{0, 14'h0000, 8'h00, 8'h00, 8'h00, 8'hC3, 1, 2, 0, 3, 0, 1};
    vecs[5] = '{1, 14'h3FFF, 8'h00, 8'h81, 8'h81, 8'h00, 3, 2, 0, 5, 4, 0};
    vecs[6] = '{2, 14'h0000, 8'h00, 8'h11, 8'h81, 8'h00, 3, 0, 2, 5, 4, 0};

    // reset state
    #2;
    chk("rst_datack", 32'(datack), 32'd1);
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_overrun", 32'(vid_overrun), 32'd0);
    chk("rst_outputs", {2'b0, ram_addr, ram_wdata, vid_data}, 32'd0);
    do_reset();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // back-to-back video: request in the grant cycle is queued, not overrun
    begin
      int vc = 0;
      int vcyc[3];
      logic [7:0] vd[3];
      do_reset();
      model_en = 1'b1;
      for (int c = 0; c < 14; c++) begin
        vid_req  = (c == 0) || (c == 2) || (c == 3);
        vid_addr = (c == 0) ? 14'h0011 : (c == 2) ? 14'h0022 : 14'h0033;
        @(negedge clk);
        if (vid_valid === 1'b1 && vc < 3) begin vcyc[vc] = c; vd[vc] = vid_data; vc++; end
        @(posedge clk); #1;
      end
      vid_req = 1'b0;
      chk("b2b_valid_count", vc, 3);
      chk("b2b_cycles", {8'd0, 8'(vcyc[0]), 8'(vcyc[1]), 8'(vcyc[2])}, {8'd0, 8'd3, 8'd6, 8'd9});
      chk("b2b_data", {8'd0, vd[0], vd[1], vd[2]}, {8'd0, 8'h4D, 8'h7E, 8'h6F});
      chk("b2b_overrun", 32'(vid_overrun), 32'd0);
    end

    // contention: CPU gets in after exactly 4 video grants
    begin
      int vcount = 0, first_we = -1;
      bit stop = 0, rel = 0, prev_oe = 0;
      do_reset();
      model_en = 1'b1; wr = 1'b1; bus_addr = 14'h0300; bus_din = 8'h55;
      for (int c = 0; c < 40; c++) begin
        vid_req  = (c % 3 == 0) && !stop;
        vid_addr = 14'h0100 + 14'(c);
        cs       = !(c >= 1 && !rel);
        @(negedge clk);
        if (!ram_oe_n && !prev_oe && c >= 4 && first_we < 0) vcount++;
        prev_oe = !ram_oe_n;
        if (!ram_we_n && first_we < 0) begin first_we = c; stop = 1; end
        if (datack === 1'b0) rel = 1;
        @(posedge clk); #1;
      end
      vid_req = 1'b0; cs = 1'b1;
      chk("starve_vid_grants", vcount, 4);
      chk("starve_cpu_cycle", first_we, 16);
      chk("starve_overrun", 32'(vid_overrun), 32'd0);
    end

    // overrun: two requests during CPU_ACC, only the second is fetched
    begin
      int a_c = 0, b_c = 0, val_c = 0;
      logic [7:0] vd = '0;
      do_reset();
      model_en = 1'b1; wr = 1'b0; bus_addr = 14'h0200;
      for (int c = 0; c < 24; c++) begin
        cs       = !(c < 8);
        vid_req  = (c == 3) || (c == 4);
        vid_addr = (c == 3) ? 14'h0AAA : 14'h0BBB;
        @(negedge clk);
        if (!ram_oe_n && ram_addr === 14'h0AAA) a_c++;
        if (!ram_oe_n && ram_addr === 14'h0BBB) b_c++;
        if (vid_valid === 1'b1) begin val_c++; vd = vid_data; end
        @(posedge clk); #1;
      end
      vid_req = 1'b0;
      chk("ovr_flag", 32'(vid_overrun), 32'd1);
      chk("ovr_first_fetched", a_c, 0);
      chk("ovr_second_fetched", b_c, 2);
      chk("ovr_valid_count", val_c, 1);
      chk("ovr_vid_data", 32'(vd), 32'hE7);
      chk("ovr_bus_dout", 32'(bus_dout), 32'h5C);
    end

    // abort: cs released while CPU_ACC is in flight
    begin
      int we_c = 0, ack_c = 0;
      bit wd_ok = 1;
      do_reset();
      wr = 1'b1; bus_addr = 14'h0155; bus_din = 8'h3C;
      for (int c = 0; c < 14; c++) begin
        cs = !(c < 2);
        @(negedge clk);
        if (!ram_we_n) begin we_c++; if (ram_wdata !== 8'h3C) wd_ok = 0; end
        if (datack !== 1'b1) ack_c++;
        @(posedge clk); #1;
      end
      chk("abort_we_cycles", we_c, 2);
      chk("abort_wdata", 32'(wd_ok), 32'd1);
      chk("abort_datack_low", ack_c, 0);
    end

    // reset pulsed while in CPU_ACK
    begin
      bit seen = 0;
      int bad = 0;
      do_reset();
      wr = 1'b0; bus_addr = 14'h0010; fix_rd = 8'hA7; cs = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge clk);
        if (datack === 1'b0) begin
          seen = 1;
          reset_n = 1'b0;
          #1;
          chk("rst_ack_datack", 32'(datack), 32'd1);
          chk("rst_ack_strobes", {ram_oe_n, ram_we_n}, 32'd3);
          chk("rst_ack_vid_valid", 32'(vid_valid), 32'd0);
          chk("rst_ack_bus_dout", 32'(bus_dout), 32'd0);
        end else begin
          @(posedge clk); #1;
        end
      end
      chk("rst_ack_reached", 32'(seen), 32'd1);
      cs = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (datack !== 1'b1 || ram_oe_n !== 1'b1 || ram_we_n !== 1'b1) bad++;
      end
      chk("rst_ack_idle_after", bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vdu_vram_arbiter.md
VDU_VRAM_ARBITER -- requirements
Module: vdu_vram_arbiter

Interface
REQ-001 Parameter RAM_WAIT, default 2: clock cycles each RAM access holds strobes, legal range 1..7.
REQ-002 Parameter CPU_STARVE, default 4: maximum consecutive video grants while a CPU access is pending.
REQ-003 One clock and an asynchronous active-low reset: clk  in  1  16 MHz bus clock, all state on rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-004 cs  in  1  STEbus VRAM chip select, active low, asynchronous to clk.
REQ-005 wr  in  1  1=write, 0=read, valid while cs low.
REQ-006 bus_addr  in  14  CPU VRAM address; bus_din  in  8  CPU write data; bus_dout  out  8  CPU read data.
REQ-007 datack  out  1  STEbus data acknowledge, active low.
REQ-008 vid_req  in  1  one-cycle scan-out fetch strobe; vid_addr  in  14  fetch address, valid with vid_req.
REQ-009 vid_data  out  8  fetched byte; vid_valid  out  1  one-cycle strobe qualifying vid_data; vid_overrun  out  1  sticky lost-request flag.
REQ-010 ram_addr  out  14; ram_wdata  out  8; ram_rdata  in  8; ram_oe_n  out  1; ram_we_n  out  1  (VRAM port).

Function
REQ-011 cs SHALL pass a two-flop synchronizer (cs_s) before any use; wr, bus_addr, bus_din SHALL be captured at CPU grant.
REQ-012 States SHALL be IDLE, VID_ACC, CPU_ACC, CPU_ACK.
REQ-013 A vid_req SHALL set a one-deep vid_pend with captured vid_addr; a vid_req while vid_pend set SHALL overwrite the address and set vid_overrun.
REQ-014 cpu_pend SHALL be cs_s low and not yet serviced in the current cs assertion; one RAM access per cs assertion.
REQ-015 IDLE: both pending and vid_streak < CPU_STARVE -> VID_ACC; both pending and vid_streak = CPU_STARVE -> CPU_ACC; single pending -> its state; none -> IDLE.
REQ-016 vid_streak SHALL increment on each video grant made while cpu_pend set, saturate at CPU_STARVE, clear on CPU grant or when cpu_pend clear.
REQ-017 VID_ACC SHALL last RAM_WAIT cycles with ram_addr=vid address, ram_oe_n=0; ram_rdata SHALL be latched into vid_data on the last cycle, vid_valid high the following cycle; FSM SHALL return to IDLE.
REQ-018 Video latency: vid_req in cycle 0 with FSM IDLE and no CPU pending -> vid_valid high in cycle RAM_WAIT+1.
REQ-019 CPU_ACC SHALL last RAM_WAIT cycles: read -> ram_oe_n=0, ram_rdata latched into bus_dout on last cycle; write -> ram_we_n=0, ram_wdata=captured bus_din.
REQ-020 After CPU_ACC, if cs_s still low -> CPU_ACK with datack=0, held until cs_s high, then datack=1 and IDLE.
REQ-021 If cs_s rises during CPU_ACC the access SHALL complete, datack SHALL stay 1, FSM SHALL go to IDLE.
REQ-022 ram_oe_n and ram_we_n SHALL never both be 0; both SHALL be 1 in IDLE and CPU_ACK.
REQ-023 bus_dout and vid_data SHALL hold until the next read of the same requester.
REQ-024 vid_req arriving in the same cycle vid_pend is granted SHALL be queued as new, not flagged overrun.

Reset
REQ-025 reset_n low SHALL force IDLE, datack=1, ram_oe_n=1, ram_we_n=1, vid_valid=0, vid_overrun=0, vid_pend=0, vid_streak=0, synchronizer flops=1, bus_dout/vid_data/ram_addr/ram_wdata=0.
REQ-026 Reset mid-access SHALL abandon the access immediately with no datack or vid_valid issued.

Structure
REQ-027 State encoding and default RAM_WAIT/CPU_STARVE SHALL live in shared package vdu_pkg.
REQ-028 The synchronizer SHALL be a sub-module vdu_sync2, reset value 1.

Verification
REQ-029 Idle video fetch: vid_req, vid_addr=0x0123, RAM=0x5A -> ram_oe_n low cycles 1-2, vid_valid with vid_data=0x5A in cycle 3.
REQ-030 CPU read: cs low, wr=0, bus_addr=0x0200, RAM=0xC3 -> ram_oe_n low 2 cycles, datack low, bus_dout=0xC3, datack high after cs_s rises.
REQ-031 CPU write: wr=1, bus_din=0x7E -> ram_we_n low exactly 2 cycles, ram_wdata=0x7E, ram_oe_n stays 1.
REQ-032 Contention: vid_req every 3 cycles, cs held low -> CPU granted after exactly 4 video grants.
REQ-033 Overrun and abort: two vid_req during CPU_ACC -> vid_overrun=1, only second address fetched; cs rises mid-CPU_ACC -> datack never low.
REQ-034 reset_n pulsed low during CPU_ACK -> datack=1, strobes=1, IDLE immediately.
